// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM states, the memory command payload and
// the access-size / misalignment helpers used by the LSU and the control unit.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b011,
        LD_LHU = 3'b100
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_type_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_cmd_t;

    // Unknown load codes behave as LW, store code 11 behaves as SW.
    function automatic size_e access_size(input logic       is_store,
                                          input logic [1:0] st_type,
                                          input logic [2:0] ld_type);
        size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (st_type)
                ST_SB:   sz = SZ_BYTE;
                ST_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (ld_type)
                LD_LB, LD_LBU: sz = SZ_BYTE;
                LD_LH, LD_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory req/gnt/rvalid port; the LSU is the master, the memory the slave.
interface lsu_mem_ctrl_if;
    import lsu_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [BE_W-1:0] dmem_be;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: byte enables and store replication on the way
// out, lane extraction and sign/zero extension on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e           st_size,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      ld_type,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_raw,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] st_data_c,
    output logic [XLEN-1:0] ld_data_c
);

    logic [XLEN-1:0] lane_c;

    // Byte enables follow the access size; narrow stores drive every lane.
    always_comb begin
        be_c      = 4'b1111;
        st_data_c = st_data;
        case (st_size)
            SZ_BYTE: begin
                be_c      = 4'b0001 << st_addr_lo;
                st_data_c = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be_c      = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_data_c = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Word-aligned LW has a zero shift, so the lane is the raw word.
    always_comb begin
        lane_c    = ld_raw >> {ld_addr_lo, 3'b000};
        ld_data_c = lane_c;
        case (ld_type)
            LD_LB:   ld_data_c = {{24{lane_c[7]}},  lane_c[7:0]};
            LD_LH:   ld_data_c = {{16{lane_c[15]}}, lane_c[15:0]};
            LD_LBU:  ld_data_c = {24'h0, lane_c[7:0]};
            LD_LHU:  ld_data_c = {16'h0, lane_c[15:0]};
            default: ld_data_c = lane_c;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: issues one data-memory access per decoded
// operation, stalls the pipeline until it completes, times out stuck accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            mem_write,
    input  logic            memtoreg,
    input  logic [2:0]      mem_load_type,
    input  logic [1:0]      mem_store_type,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            lsu_stall,
    output logic            lsu_done,
    output logic [XLEN-1:0] rdata_out,
    output logic            misalign,
    output logic            timeout_err,
    lsu_mem_ctrl_if.master  dmem
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    state_e          state_d;
    dmem_cmd_t       cmd_q;
    logic [2:0]      ld_type_q;
    logic [1:0]      addr_lo_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [XLEN-1:0] rdata_q;
    logic            tmo_q;

    logic            start_c;
    logic            start_ok_c;
    logic            mis_c;
    logic            tmo_hit_c;
    logic            tmo_set_c;
    size_e           size_c;
    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] st_data_c;
    logic [XLEN-1:0] ld_data_c;

    assign start_c   = ex_valid & (mem_write | memtoreg);
    assign size_c    = access_size(mem_write, mem_store_type, mem_load_type);
    assign mis_c     = is_misaligned(size_c, addr[1:0]);
    assign tmo_hit_c = (tmo_cnt_q == TMO_LAST);

    lsu_align u_align (
        .st_size    (size_c),
        .st_addr_lo (addr[1:0]),
        .st_data    (wdata),
        .ld_type    (ld_type_q),
        .ld_addr_lo (addr_lo_q),
        .ld_raw     (dmem.dmem_rdata),
        .be_c       (be_c),
        .st_data_c  (st_data_c),
        .ld_data_c  (ld_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the stall/done/misalign strobes decoded from state.
    always_comb begin
        state_d    = state_q;
        lsu_stall  = 1'b0;
        lsu_done   = 1'b0;
        misalign   = 1'b0;
        start_ok_c = 1'b0;
        tmo_set_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    if (mis_c) begin
                        misalign = 1'b1;
                        lsu_done = 1'b1;
                    end else begin
                        lsu_stall  = 1'b1;
                        start_ok_c = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (dmem.dmem_gnt) begin
                    state_d = cmd_q.we ? DONE : WAIT;
                end else if (tmo_hit_c) begin
                    state_d   = DONE;
                    tmo_set_c = 1'b1;
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    state_d = DONE;
                end else if (tmo_hit_c) begin
                    state_d   = DONE;
                    tmo_set_c = 1'b1;
                end
            end
            DONE: begin
                lsu_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command capture, timeout counter and load-result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            ld_type_q <= '0;
            addr_lo_q <= '0;
            tmo_cnt_q <= '0;
            rdata_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_q <= tmo_set_c;

            if (start_ok_c) begin
                cmd_q.we    <= mem_write;
                cmd_q.be    <= be_c;
                cmd_q.addr  <= {addr[XLEN-1:2], 2'b00};
                cmd_q.wdata <= mem_write ? st_data_c : '0;
                ld_type_q   <= mem_load_type;
                addr_lo_q   <= addr[1:0];
            end

            if ((state_q == REQ || state_q == WAIT) && (state_d == REQ || state_d == WAIT)) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end

            // Cleared when DONE retires so it reads zero outside a load completion.
            if (state_q == WAIT && dmem.dmem_rvalid) begin
                rdata_q <= ld_data_c;
            end else if (state_q == DONE) begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata_out       = rdata_q;
    assign timeout_err     = tmo_q;
    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = cmd_q.we;
    assign dmem.dmem_be    = cmd_q.be;
    assign dmem.dmem_addr  = cmd_q.addr;
    assign dmem.dmem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table with a completion scoreboard, plus
// hand sequences for timeout and reset during an outstanding load.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TO_SHORT = 4;
    localparam int          BUDGET   = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        mem_write;
    logic        memtoreg;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        lsu_stall, lsu_done, misalign, timeout_err;
    logic [31:0] rdata_out;
    logic        stall_to, done_to, mis_to, tmo_to;
    logic [31:0] rdata_to;

    lsu_mem_ctrl_if mif ();
    lsu_mem_ctrl_if mif_to ();

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_write(mem_write),
        .memtoreg(memtoreg), .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
        .rdata_out(rdata_out), .misalign(misalign), .timeout_err(timeout_err), .dmem(mif)
    );

    lsu_mem_ctrl #(.TIMEOUT_CYC(TO_SHORT)) dut_to (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_write(mem_write),
        .memtoreg(memtoreg), .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .addr(addr), .wdata(wdata), .lsu_stall(stall_to), .lsu_done(done_to),
        .rdata_out(rdata_to), .misalign(mis_to), .timeout_err(tmo_to), .dmem(mif_to)
    );

    typedef struct {
        bit          wr;
        bit          rd;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
        int          done_k;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        exp_t        got;
        int          stall_n;
        int          done_k;
        bit          req_seen;
        bit          req_bad;
        logic [31:0] first_addr;
        logic [31:0] first_wdata;
        logic [3:0]  first_be;
        logic        first_we;

        @(posedge clk); #1;
        ex_valid       = 1'b1;
        mem_write      = v.wr;
        memtoreg       = v.rd;
        mem_load_type  = v.lt;
        mem_store_type = v.st;
        addr           = v.addr;
        wdata          = v.wdata;
        mif.dmem_rdata = v.rdata;

        e.rdata  = v.exp_rdata;
        e.mis    = v.exp_mis;
        e.done_k = v.exp_mis ? 0 : (v.wr ? 2 + v.gnt_dly : 3 + v.gnt_dly + v.rv_dly);
        sb.push_back(e);

        stall_n = 0; done_k = -1; req_seen = 1'b0; req_bad = 1'b0;
        first_addr = '0; first_wdata = '0; first_be = '0; first_we = 1'b0;
        for (int k = 0; k < BUDGET && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                ex_valid = 1'b0;
            end
            mif.dmem_gnt    = (k == 1 + v.gnt_dly);
            mif.dmem_rvalid = (!v.wr && k == 2 + v.gnt_dly + v.rv_dly);
            @(negedge clk);
            if (lsu_stall) stall_n++;
            if (mif.dmem_req) begin
                if (!req_seen) begin
                    first_we = mif.dmem_we; first_be = mif.dmem_be;
                    first_addr = mif.dmem_addr; first_wdata = mif.dmem_wdata;
                    chk($sformatf("v%0d we", idx), 32'(mif.dmem_we), 32'(v.wr));
                    chk($sformatf("v%0d be", idx), 32'(mif.dmem_be), 32'(v.exp_be));
                    chk($sformatf("v%0d dmem_addr", idx), mif.dmem_addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d dmem_wdata", idx), mif.dmem_wdata, v.exp_wdata);
                end else if (mif.dmem_we !== first_we || mif.dmem_be !== first_be ||
                             mif.dmem_addr !== first_addr || mif.dmem_wdata !== first_wdata) begin
                    req_bad = 1'b1;
                end
                req_seen = 1'b1;
            end
            if (lsu_done) begin
                done_k = k;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected done", idx), 32'(1), 32'(0));
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d done cycle", idx), 32'(k), 32'(got.done_k));
                    chk($sformatf("v%0d rdata_out", idx), rdata_out, got.rdata);
                    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(got.mis));
                    chk($sformatf("v%0d timeout_err", idx), 32'(timeout_err), 32'(0));
                end
            end
        end
        if (done_k < 0) begin
            chk($sformatf("v%0d done within budget", idx), 32'(0), 32'(1));
            sb.delete();
        end
        chk($sformatf("v%0d stall cycles", idx), 32'(stall_n), 32'(e.done_k));
        chk($sformatf("v%0d req issued", idx), 32'(req_seen), 32'(!v.exp_mis));
        chk($sformatf("v%0d req stable", idx), 32'(req_bad), 32'(0));
    endtask

    initial begin
        int to_k;
        bit late_done;

        //         wr    rd    lt      st     addr          wdata         rdata         g  r  be       exp_wdata     exp_rdata     mis
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 2'b00, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 2'b01, 32'h0000_0102, 32'h1234_BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 2'b00, 32'h0000_0101, 32'h0,        32'h1234_8056, 0, 0, 4'b0010, 32'h0,        32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd3, 2'b00, 32'h0000_0101, 32'h0,        32'h1234_8056, 0, 0, 4'b0010, 32'h0,        32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd4, 2'b00, 32'h0000_0102, 32'h0,        32'h1234_8056, 0, 0, 4'b1100, 32'h0,        32'h0000_1234, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd1, 2'b00, 32'h0000_0102, 32'h0,        32'h8000_1234, 0, 0, 4'b1100, 32'h0,        32'hFFFF_8000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 2'b00, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 2'b00, 32'h0000_0102, 32'h0,        32'h1111_1111, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 2'b00, 32'h0000_0103, 32'h0,        32'h2222_2222, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 2'b10, 32'h0000_0101, 32'h3333_3333, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd2, 2'b00, 32'h0000_0108, 32'h0,        32'h0BAD_C0DE, 2, 1, 4'b1111, 32'h0,        32'h0BAD_C0DE, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd0, 2'b01, 32'h0000_0100, 32'h0000_ABCD, 32'h0,        3, 0, 4'b0011, 32'hABCD_ABCD, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 2'b00, 32'h0000_010C, 32'h0,        32'h0102_0304, 0, 0, 4'b1111, 32'h0,        32'h0102_0304, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd2, 2'b00, 32'h0000_0111, 32'h0000_005A, 32'h0,        0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'd3, 2'b00, 32'h0000_0103, 32'h0,        32'hF000_0000, 0, 2, 4'b1000, 32'h0,        32'h0000_00F0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'd0, 2'b11, 32'h0000_0114, 32'h1357_9BDF, 32'h0,        0, 0, 4'b1111, 32'h1357_9BDF, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 1'b1, 3'd0, 2'b00, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 0, 4'b0001, 32'h0,        32'h0000_007F, 1'b0};

        rst_n = 1'b0; ex_valid = 1'b0; mem_write = 1'b0; memtoreg = 1'b0;
        mem_load_type = '0; mem_store_type = '0; addr = '0; wdata = '0;
        mif.dmem_gnt = 1'b0; mif.dmem_rvalid = 1'b0; mif.dmem_rdata = '0;
        mif_to.dmem_gnt = 1'b0; mif_to.dmem_rvalid = 1'b0; mif_to.dmem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(lsu_stall), 32'(0));
        chk("reset done", 32'(lsu_done), 32'(0));
        chk("reset req", 32'(mif.dmem_req), 32'(0));
        chk("reset be/we", 32'({mif.dmem_we, mif.dmem_be}), 32'(0));
        chk("reset addr", mif.dmem_addr, 32'h0);
        chk("reset wdata", mif.dmem_wdata, 32'h0);
        chk("reset rdata_out", rdata_out, 32'h0);
        chk("reset flags", 32'({misalign, timeout_err}), 32'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Timeout: the short-timeout instance never sees gnt.
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_write = 1'b0; memtoreg = 1'b0;
        mif.dmem_gnt = 1'b0; mif.dmem_rvalid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        ex_valid = 1'b1; memtoreg = 1'b1; mem_write = 1'b0;
        mem_load_type = 3'b010; addr = 32'h0000_0200; wdata = 32'h0;
        to_k = -1;
        for (int k = 0; k < 20 && to_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                ex_valid = 1'b0;
            end
            @(negedge clk);
            if (k == 1) begin
                chk("to stall in REQ", 32'(stall_to), 32'(1));
                chk("to req", 32'(mif_to.dmem_req), 32'(1));
                chk("to we/be", 32'({mif_to.dmem_we, mif_to.dmem_be}), 32'(5'b01111));
                chk("to addr", mif_to.dmem_addr, 32'h0000_0200);
                chk("to wdata", mif_to.dmem_wdata, 32'h0);
            end
            if (done_to) begin
                to_k = k;
                chk("to timeout_err", 32'(tmo_to), 32'(1));
                chk("to rdata_out", rdata_to, 32'h0);
                chk("to misalign", 32'(mis_to), 32'(0));
            end
        end
        chk("to done cycle", 32'(to_k), 32'(1 + TO_SHORT));

        // Main instance is still in REQ: grant it, then reset while in WAIT.
        @(posedge clk); #1;
        mif.dmem_gnt = 1'b1;
        @(posedge clk); #1;
        mif.dmem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst wait stall", 32'(lsu_stall), 32'(1));
        chk("rst wait req", 32'(mif.dmem_req), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.dmem_rvalid = 1'b1;
        mif.dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("post-rst stall", 32'(lsu_stall), 32'(0));
        chk("post-rst req", 32'(mif.dmem_req), 32'(0));
        late_done = lsu_done;
        @(posedge clk); #1;
        mif.dmem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            late_done = late_done | lsu_done;
        end
        chk("late rvalid done", 32'(late_done), 32'(0));
        chk("late rvalid rdata", rdata_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
